// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the two-requester shift arbiter: datapath widths and requester ids.
package shift_arbiter_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SH_W   = 5;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Shift amounts at or beyond the operand width flood the result with the fill bit.
    localparam logic [SH_W-1:0] SH_FULL = SH_W'(DATA_W);

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational right shifter: logical or arithmetic, with amounts >= DATA_W saturating to the fill bit.
import shift_arbiter_pkg::*;

module right_shifter (
    input  logic [DATA_W-1:0] data,
    input  logic [SH_W-1:0]   sh,
    input  logic              sign,
    output logic [DATA_W-1:0] result
);

    logic              ext;
    logic signed [DATA_W:0] wide;
    logic signed [DATA_W:0] shifted;

    // One extra top bit carries the fill value so a single arithmetic shift covers both modes.
    always_comb begin
        ext     = sign && data[DATA_W-1];
        wide    = {ext, data};
        shifted = wide >>> sh;
        result  = (sh >= SH_FULL) ? {DATA_W{ext}} : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of a shared right shifter, with a single registered result stage.
import shift_arbiter_pkg::*;

module shift_arbiter (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [SH_W-1:0]   req0_sh,
    input  logic              req0_sign,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [SH_W-1:0]   req1_sh,
    input  logic              req1_sign,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data
);

    logic              prio;
    logic              accept;
    logic              grant0;
    logic              grant1;
    logic              take;
    logic              sel;
    logic [DATA_W-1:0] op_data;
    logic [SH_W-1:0]   op_sh;
    logic              op_sign;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        accept     = !rsp_valid || rsp_ready;
        grant0     = req0_valid && (!req1_valid || prio == REQ0);
        grant1     = req1_valid && (!req0_valid || prio == REQ1);
        req0_ready = !rst && accept && grant0;
        req1_ready = !rst && accept && grant1;
        take       = req0_ready || req1_ready;
        sel        = grant1 ? REQ1 : REQ0;
        op_data    = sel ? req1_data : req0_data;
        op_sh      = sel ? req1_sh   : req0_sh;
        op_sign    = sel ? req1_sign : req0_sign;
    end

    right_shifter u_shifter (
        .data   (op_data),
        .sh     (op_sh),
        .sign   (op_sign),
        .result (shifted)
    );

    // A load takes precedence over a drain so back-to-back transfers never bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= REQ0;
            prio      <= REQ0;
        end else if (take) begin
            rsp_valid <= 1'b1;
            rsp_data  <= shifted;
            rsp_id    <= sel;
            prio      <= ~sel;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: directed requests push hand-computed results, a monitor checks each response transfer.
import shift_arbiter_pkg::*;

module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sign;
    logic [15:0] req0_data;
    logic [4:0]  req0_sh;
    logic        req1_valid, req1_ready, req1_sign;
    logic [15:0] req1_data;
    logic [4:0]  req1_sh;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_data;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [16:0] sb[$];

    always #5 clk = ~clk;

    shift_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_sh(req0_sh), .req0_sign(req0_sign),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_sh(req1_sh), .req1_sign(req1_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response transfer must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id %0d data %h expected no response", rsp_id, rsp_data);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                if ({rsp_id, rsp_data} !== e) begin
                    errors++;
                    $display("FAIL rsp: got id %0d data %h expected id %0d data %h",
                             rsp_id, rsp_data, e[16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = '0; req0_sh = '0; req0_sign = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_sh = '0; req1_sign = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'h0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_req0_ready", 32'(req0_ready), 32'd0);
        step();
        rst = 1'b0;

        // Arithmetic / logical and saturating shifts
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 16'h8000; req0_sh = 5'd4; req0_sign = 1'b1;
        @(negedge clk); check("a0_ready", 32'(req0_ready), 32'd1); sb.push_back({1'b0, 16'hF800});
        step(); req0_sign = 1'b0;
        @(negedge clk); check("a1_ready", 32'(req0_ready), 32'd1); sb.push_back({1'b0, 16'h0800});
        check("a1_latency_valid", 32'(rsp_valid), 32'd1);
        step(); req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 16'h8001; req1_sh = 5'd16; req1_sign = 1'b1;
        @(negedge clk); check("l0_ready", 32'(req1_ready), 32'd1); sb.push_back({1'b1, 16'hFFFF});
        step(); req1_sh = 5'd31; req1_sign = 1'b0;
        @(negedge clk); check("l1_ready", 32'(req1_ready), 32'd1); sb.push_back({1'b1, 16'h0000});
        step(); req1_valid = 1'b0;
        step();

        // Round robin from reset
        rst = 1'b1; sb.delete();
        step(); rst = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h00F0; req0_sh = 5'd4; req0_sign = 1'b0;
        req1_valid = 1'b1; req1_data = 16'hF000; req1_sh = 5'd8; req1_sign = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_ready0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_ready1", 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k > 0) check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            if (k % 2 == 0) sb.push_back({1'b0, 16'h000F});
            else            sb.push_back({1'b1, 16'hFFF0});
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); check("rr_tail_valid", 32'(rsp_valid), 32'd1);
        step();

        // Backpressure with 16'h1234 held
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h1234; req0_sh = 5'd0; req0_sign = 1'b0;
        @(negedge clk); check("bp_load_ready", 32'(req0_ready), 32'd1); sb.push_back({1'b0, 16'h1234});
        step();
        req1_valid = 1'b1; req1_data = 16'h00FF; req1_sh = 5'd4; req1_sign = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready0", 32'(req0_ready), 32'd0);
            check("bp_ready1", 32'(req1_ready), 32'd0);
            check("bp_hold", {15'd0, rsp_valid, rsp_id, rsp_data}, {15'd0, 1'b1, 1'b0, 16'h1234});
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_ready1", 32'(req1_ready), 32'd1);
        check("bp_resume_ready0", 32'(req0_ready), 32'd0);
        sb.push_back({1'b1, 16'h000F});
        step(); req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); check("bp_no_bubble", {30'd0, rsp_valid, rsp_id}, {30'd0, 1'b1, 1'b1});
        step();

        // Reset while a result is held and prio points at requester 1
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h5555; req0_sh = 5'd1; req0_sign = 1'b0;
        @(negedge clk); check("rh_load_ready", 32'(req0_ready), 32'd1); sb.push_back({1'b0, 16'h2AAA});
        step(); req0_valid = 1'b0; req1_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("rh_held_valid", 32'(rsp_valid), 32'd1);
        check("rh_ready_in_reset", 32'(req1_ready), 32'd0);
        sb.delete();
        step(); rst = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 16'hFF00; req0_sh = 5'd8; req0_sign = 1'b1;
        req1_valid = 1'b1; req1_data = 16'h0F0F; req1_sh = 5'd4; req1_sign = 1'b0;
        @(negedge clk);
        check("rh_cleared", {15'd0, rsp_valid, rsp_id, rsp_data}, 32'd0);
        check("rh_ready0", 32'(req0_ready), 32'd1);
        check("rh_ready1", 32'(req1_ready), 32'd0);
        sb.push_back({1'b0, 16'hFFFF});
        step(); req0_valid = 1'b0;
        @(negedge clk); check("rh_next_ready1", 32'(req1_ready), 32'd1); sb.push_back({1'b1, 16'h00F0});
        step(); req1_valid = 1'b0;

        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
